// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bundle: hazard inputs gathered from the pipeline
// stages and the stall/flush/PC controls returned to them.
interface pipe_hazard_ctrl_if;
    // Hazard sources from ID/EX/M1 and the memories
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic [4:0]  m1_rd;
    logic        ex_is_load;
    logic        m1_is_load;
    logic        ex_valid;
    logic        m1_valid;
    logic        ex_redirect;
    logic        trap_req;
    logic        mret_req;
    logic        imem_wait;
    logic        dmem_wait;

    // Sequencing controls back to the pipeline registers and PC
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        stall_f_d;
    logic        stall_d_e;
    logic        stall_e_m1;
    logic        stall_m1_m2;
    logic        stall_m2_w;
    logic        flush_f_d;
    logic        flush_d_e;
    logic        flush_e_m1;
    logic        flush_m1_m2;
    logic        busy;
    logic [31:0] stall_cycles;

    // Pipeline side: supplies hazard information, consumes controls
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, m1_rd,
               ex_is_load, m1_is_load, ex_valid, m1_valid, ex_redirect,
               trap_req, mret_req, imem_wait, dmem_wait,
        input  pc_en, pc_sel, stall_f_d, stall_d_e, stall_e_m1, stall_m1_m2,
               stall_m2_w, flush_f_d, flush_d_e, flush_e_m1, flush_m1_m2,
               busy, stall_cycles
    );

    // Controller side
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, m1_rd,
               ex_is_load, m1_is_load, ex_valid, m1_valid, ex_redirect,
               trap_req, mret_req, imem_wait, dmem_wait,
        output pc_en, pc_sel, stall_f_d, stall_d_e, stall_e_m1, stall_m1_m2,
               stall_m2_w, flush_f_d, flush_d_e, flush_e_m1, flush_m1_m2,
               busy, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencing unit for the six-stage core: load-use interlock,
// EX redirects, memory waits, MRET and trap entry with a back-end drain.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               nrst,
    pipe_hazard_ctrl_if.slave  hz
);

    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 7) begin : g_bad_drain
        $error("DRAIN_CYCLES must lie in 1..7");
    end

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        TRAP_DRAIN = 2'd1,
        TRAP_VEC   = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEQ   = 2'd0;
    localparam logic [1:0] PC_REDIR = 2'd1;
    localparam logic [1:0] PC_TRAP  = 2'd2;
    localparam logic [1:0] PC_MEPC  = 2'd3;

    state_t      fsm;
    logic [2:0]  drain_cnt;
    logic [31:0] stall_cycles_q;
    logic        lu;

    // A source is hazardous when a load still in EX or M1 writes it (x0 never is)
    function automatic logic src_hazard(
        input logic [4:0] rs,
        input logic       use_rs,
        input logic       ex_ld,
        input logic [4:0] ex_dst,
        input logic       m1_ld,
        input logic [4:0] m1_dst
    );
        return use_rs && (rs != 5'd0) &&
               ((ex_ld && ex_dst == rs) || (m1_ld && m1_dst == rs));
    endfunction

    // Load-use detection for both ID source operands
    always_comb begin
        lu = src_hazard(hz.id_rs1, hz.id_use_rs1,
                        hz.ex_valid && hz.ex_is_load, hz.ex_rd,
                        hz.m1_valid && hz.m1_is_load, hz.m1_rd) ||
             src_hazard(hz.id_rs2, hz.id_use_rs2,
                        hz.ex_valid && hz.ex_is_load, hz.ex_rd,
                        hz.m1_valid && hz.m1_is_load, hz.m1_rd);
    end

    // Stall/flush/PC decode; during reset every register is held as a bubble
    always_comb begin
        hz.pc_en       = 1'b0;
        hz.pc_sel      = PC_SEQ;
        hz.stall_f_d   = 1'b0;
        hz.stall_d_e   = 1'b0;
        hz.stall_e_m1  = 1'b0;
        hz.stall_m1_m2 = 1'b0;
        hz.stall_m2_w  = 1'b0;
        hz.flush_f_d   = 1'b0;
        hz.flush_d_e   = 1'b0;
        hz.flush_e_m1  = 1'b0;
        hz.flush_m1_m2 = 1'b0;
        if (!nrst) begin
            hz.flush_f_d   = 1'b1;
            hz.flush_d_e   = 1'b1;
            hz.flush_e_m1  = 1'b1;
            hz.flush_m1_m2 = 1'b1;
        end else begin
            case (fsm)
                RUN: begin
                    if (hz.dmem_wait) begin
                        // Data memory wait freezes the whole pipe, nothing else acts
                        hz.stall_f_d   = 1'b1;
                        hz.stall_d_e   = 1'b1;
                        hz.stall_e_m1  = 1'b1;
                        hz.stall_m1_m2 = 1'b1;
                        hz.stall_m2_w  = 1'b1;
                    end else if (hz.trap_req) begin
                        hz.flush_f_d   = 1'b1;
                        hz.flush_d_e   = 1'b1;
                        hz.flush_e_m1  = 1'b1;
                        hz.flush_m1_m2 = 1'b1;
                    end else if (hz.mret_req) begin
                        hz.flush_f_d  = 1'b1;
                        hz.flush_d_e  = 1'b1;
                        hz.flush_e_m1 = 1'b1;
                        hz.pc_en      = 1'b1;
                        hz.pc_sel     = PC_MEPC;
                    end else if (hz.ex_redirect) begin
                        // Wrong-path fetch is discarded, so lu/imem_wait are moot
                        hz.flush_f_d = 1'b1;
                        hz.flush_d_e = 1'b1;
                        hz.pc_en     = 1'b1;
                        hz.pc_sel    = PC_REDIR;
                    end else if (lu || hz.imem_wait) begin
                        // Hold ID, inject a bubble into EX
                        hz.stall_f_d = 1'b1;
                        hz.flush_d_e = 1'b1;
                    end else begin
                        hz.pc_en = 1'b1;
                    end
                end
                TRAP_DRAIN: begin
                    hz.flush_f_d   = 1'b1;
                    hz.flush_d_e   = 1'b1;
                    hz.flush_e_m1  = 1'b1;
                    hz.flush_m1_m2 = 1'b1;
                    hz.stall_m2_w  = hz.dmem_wait;
                end
                TRAP_VEC: begin
                    hz.flush_f_d = 1'b1;
                    hz.flush_d_e = 1'b1;
                    hz.pc_en     = 1'b1;
                    hz.pc_sel    = PC_TRAP;
                end
                default: ;
            endcase
        end
    end

    assign hz.busy         = (fsm != RUN);
    assign hz.stall_cycles = stall_cycles_q;

    // Trap sequencer: drain M2/WB for DRAIN_CYCLES non-waiting cycles, then vector
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fsm       <= RUN;
            drain_cnt <= 3'd0;
        end else begin
            case (fsm)
                RUN: begin
                    if (!hz.dmem_wait && hz.trap_req) begin
                        fsm       <= TRAP_DRAIN;
                        drain_cnt <= 3'(DRAIN_CYCLES - 1);
                    end
                end
                TRAP_DRAIN: begin
                    if (!hz.dmem_wait) begin
                        if (drain_cnt == 3'd0) begin
                            fsm <= TRAP_VEC;
                        end else begin
                            drain_cnt <= drain_cnt - 3'd1;
                        end
                    end
                end
                TRAP_VEC: begin
                    fsm <= RUN;
                end
                default: begin
                    fsm <= RUN;
                end
            endcase
        end
    end

    // Performance counter of cycles in which the PC did not advance
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cycles_q <= 32'd0;
        end else if (!hz.pc_en) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle stimulus with expected control
// vectors queued at drive time and checked at the following negedge.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic nrst;

    pipe_hazard_ctrl_if hif ();

    pipe_hazard_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk  (clk),
        .nrst (nrst),
        .hz   (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       nrst;
        logic [4:0] id_rs1, id_rs2;
        logic       id_use_rs1, id_use_rs2;
        logic [4:0] ex_rd, m1_rd;
        logic       ex_is_load, m1_is_load, ex_valid, m1_valid;
        logic       ex_redirect, trap_req, mret_req, imem_wait, dmem_wait;
    } in_t;

    typedef struct {
        string       tag;
        logic [12:0] vec;
    } exp_t;

    // Expected vector layout: {busy, pc_en, pc_sel[1:0], stall f_d..m2_w, flush f_d..m1_m2}
    localparam logic [12:0] E_RST   = {1'b0, 1'b0, 2'd0, 5'b00000, 4'b1111};
    localparam logic [12:0] E_RUN   = {1'b0, 1'b1, 2'd0, 5'b00000, 4'b0000};
    localparam logic [12:0] E_LU    = {1'b0, 1'b0, 2'd0, 5'b10000, 4'b0100};
    localparam logic [12:0] E_REDIR = {1'b0, 1'b1, 2'd1, 5'b00000, 4'b1100};
    localparam logic [12:0] E_MRET  = {1'b0, 1'b1, 2'd3, 5'b00000, 4'b1110};
    localparam logic [12:0] E_DMEM  = {1'b0, 1'b0, 2'd0, 5'b11111, 4'b0000};
    localparam logic [12:0] E_TRAP  = {1'b0, 1'b0, 2'd0, 5'b00000, 4'b1111};
    localparam logic [12:0] E_DRN   = {1'b1, 1'b0, 2'd0, 5'b00000, 4'b1111};
    localparam logic [12:0] E_DRNW  = {1'b1, 1'b0, 2'd0, 5'b00001, 4'b1111};
    localparam logic [12:0] E_VEC   = {1'b1, 1'b1, 2'd2, 5'b00000, 4'b1100};

    int   n_chk = 0;
    int   n_bad = 0;
    int   exp_sc = 0;
    in_t  s;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic in_t idle();
        in_t r;
        r.nrst = 1'b1;
        r.id_rs1 = 5'd0; r.id_rs2 = 5'd0;
        r.id_use_rs1 = 1'b0; r.id_use_rs2 = 1'b0;
        r.ex_rd = 5'd0; r.m1_rd = 5'd0;
        r.ex_is_load = 1'b0; r.m1_is_load = 1'b0;
        r.ex_valid = 1'b0; r.m1_valid = 1'b0;
        r.ex_redirect = 1'b0; r.trap_req = 1'b0; r.mret_req = 1'b0;
        r.imem_wait = 1'b0; r.dmem_wait = 1'b0;
        return r;
    endfunction

    task automatic apply(input in_t i);
        nrst            = i.nrst;
        hif.id_rs1      = i.id_rs1;
        hif.id_rs2      = i.id_rs2;
        hif.id_use_rs1  = i.id_use_rs1;
        hif.id_use_rs2  = i.id_use_rs2;
        hif.ex_rd       = i.ex_rd;
        hif.m1_rd       = i.m1_rd;
        hif.ex_is_load  = i.ex_is_load;
        hif.m1_is_load  = i.m1_is_load;
        hif.ex_valid    = i.ex_valid;
        hif.m1_valid    = i.m1_valid;
        hif.ex_redirect = i.ex_redirect;
        hif.trap_req    = i.trap_req;
        hif.mret_req    = i.mret_req;
        hif.imem_wait   = i.imem_wait;
        hif.dmem_wait   = i.dmem_wait;
    endtask

    function automatic logic [12:0] obs();
        return {hif.busy, hif.pc_en, hif.pc_sel,
                hif.stall_f_d, hif.stall_d_e, hif.stall_e_m1, hif.stall_m1_m2, hif.stall_m2_w,
                hif.flush_f_d, hif.flush_d_e, hif.flush_e_m1, hif.flush_m1_m2};
    endfunction

    // One clock cycle: drive s shortly after posedge, queue expectation, check at negedge
    task automatic cyc(input string tag, input logic [12:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        apply(s);
        sb.push_back('{tag, e});
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            chk(x.tag, {19'd0, obs()}, {19'd0, x.vec});
            if (!nrst) exp_sc = 0;
            chk({x.tag, "_sc"}, hif.stall_cycles, 32'(exp_sc));
            if (nrst && !x.vec[11]) exp_sc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        s = idle();
        s.nrst = 1'b0;
        apply(s);

        cyc("reset0", E_RST);
        cyc("reset1", E_RST);
        s = idle();
        cyc("run_idle", E_RUN);

        // Load x5 in EX, ID reads rs1=5: two bubbles then proceed
        s.ex_valid = 1'b1; s.ex_is_load = 1'b1; s.ex_rd = 5'd5;
        s.id_rs1 = 5'd5; s.id_use_rs1 = 1'b1;
        cyc("lu_ex", E_LU);
        s.ex_valid = 1'b0; s.ex_is_load = 1'b0;
        s.m1_valid = 1'b1; s.m1_is_load = 1'b1; s.m1_rd = 5'd5;
        cyc("lu_m1", E_LU);
        s = idle();
        cyc("lu_done", E_RUN);

        // rs2 hazard from M1, then same hazard without the use flag
        s.m1_valid = 1'b1; s.m1_is_load = 1'b1; s.m1_rd = 5'd7;
        s.id_rs2 = 5'd7; s.id_use_rs2 = 1'b1;
        cyc("lu_rs2", E_LU);
        s.id_use_rs2 = 1'b0;
        cyc("no_use", E_RUN);

        // Load to x0 never interlocks; an invalid EX load never interlocks
        s = idle();
        s.ex_valid = 1'b1; s.ex_is_load = 1'b1; s.ex_rd = 5'd0;
        s.id_rs1 = 5'd0; s.id_use_rs1 = 1'b1;
        cyc("x0_load", E_RUN);
        s.ex_valid = 1'b0; s.ex_rd = 5'd5; s.id_rs1 = 5'd5;
        cyc("ex_invalid", E_RUN);

        // Redirect overrides load-use and imem_wait
        s.ex_valid = 1'b1; s.ex_redirect = 1'b1;
        cyc("redir_lu", E_REDIR);
        s = idle();
        s.imem_wait = 1'b1;
        cyc("imem_wait", E_LU);
        s.ex_redirect = 1'b1;
        cyc("redir_imem", E_REDIR);
        s = idle();
        s.mret_req = 1'b1; s.ex_redirect = 1'b1;
        cyc("mret", E_MRET);

        // dmem_wait masks a trap request
        s = idle();
        s.dmem_wait = 1'b1; s.trap_req = 1'b1;
        cyc("dmem_trap", E_DMEM);

        // Trap with no memory wait: 2 drain cycles, vector, back to RUN
        s = idle();
        s.trap_req = 1'b1;
        cyc("trap", E_TRAP);
        s = idle();
        s.ex_redirect = 1'b1; s.mret_req = 1'b1;
        cyc("drain0", E_DRN);
        cyc("drain1", E_DRN);
        cyc("vec", E_VEC);
        s = idle();
        cyc("after_vec", E_RUN);

        // Trap with dmem_wait for 3 drain cycles: vector delayed by 3
        s.trap_req = 1'b1;
        cyc("trap_w", E_TRAP);
        s = idle();
        s.dmem_wait = 1'b1;
        for (int k = 0; k < 3; k++) cyc("drain_wait", E_DRNW);
        s.dmem_wait = 1'b0;
        cyc("drain_w0", E_DRN);
        cyc("drain_w1", E_DRN);
        cyc("vec_w", E_VEC);
        s = idle();
        cyc("after_vec_w", E_RUN);

        // Reset pulse mid-drain: back to RUN, no pending trap
        s.trap_req = 1'b1;
        cyc("trap_r", E_TRAP);
        s = idle();
        cyc("drain_r", E_DRN);
        s.nrst = 1'b0;
        cyc("rst_mid0", E_RST);
        cyc("rst_mid1", E_RST);
        s = idle();
        cyc("rst_release", E_RUN);
        cyc("rst_run", E_RUN);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
